// File: rtl/tx_send_scheduler_pkg.sv
// Shared types and defaults for the Tx send scheduler: FSM state encoding,
// default timing constants and the burst-length helper.
package tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_BUSY,
        ST_SENDING,
        ST_GAP
    } sched_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_GAP_CYCLES      = 50000;
    localparam int unsigned DEF_START_TIMEOUT   = 1024;
    localparam int unsigned DEF_AUTO_PERIOD     = 50000000;
    localparam int unsigned DEF_BURST_W         = 4;

    // A burst length of zero still sends one frame.
    function automatic logic [31:0] max_one(input logic [31:0] burst);
        return (burst == 32'd0) ? 32'd1 : burst;
    endfunction

endpackage

// File: rtl/tx_send_scheduler_if.sv
// Start/busy handshake between the send scheduler (master) and tx_transmitter (slave).
interface tx_send_scheduler_if;
    logic tx_start;
    logic tx_busy;

    modport master (output tx_start, input tx_busy);
    modport slave  (input tx_start, output tx_busy);
endinterface

// File: rtl/tx_send_scheduler_debouncer.sv
// Key debouncer: 2-flop synchronizer plus run-length counter; emits a one-cycle
// press_evt on each accepted release->press transition. Reusable for other keys.
module tx_key_debouncer
    import tx_sched_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized key disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_evt = press_q;

endmodule

// File: rtl/tx_send_scheduler.sv
// Tx send scheduler: debounced Send key -> burst of tx_start pulses with busy
// tracking, inter-frame gap, one-deep press queue, start timeout and frame count.
// Optional auto-repeat in IDLE is enabled by defining TX_SCHED_AUTO_EN.
module tx_send_scheduler
    import tx_sched_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int unsigned START_TIMEOUT   = DEF_START_TIMEOUT,
    parameter int unsigned BURST_W         = DEF_BURST_W
`ifdef TX_SCHED_AUTO_EN
    ,
    parameter int unsigned AUTO_PERIOD     = DEF_AUTO_PERIOD
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_n,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               err_clr,
`ifdef TX_SCHED_AUTO_EN
    input  logic               auto_en,
`endif
    tx_send_scheduler_if.master txif,
    output logic               sched_busy,
    output logic [7:0]         frame_cnt,
    output logic               err_timeout
);

    localparam int unsigned TMO_W = $clog2(START_TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    sched_state_e     state_q, state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic             pending_q, pending_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       frame_q, frame_d;
    logic             err_q, err_d;
    logic             tx_start_q, tx_start_d;
    logic             press_evt;
    logic             press_any;
    logic [BURST_W-1:0] reload;

    tx_key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .press_evt(press_evt)
    );

`ifdef TX_SCHED_AUTO_EN
    localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD + 1);

    logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
    logic              auto_evt;

    // Period counter only runs while idle and enabled; anything else restarts it.
    always_comb begin
        auto_cnt_d = '0;
        auto_evt   = 1'b0;
        if (auto_en && state_q == ST_IDLE) begin
            if (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1)) begin
                auto_evt = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + AUTO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt_q <= '0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign press_any = press_evt | auto_evt;
`else
    assign press_any = press_evt;
`endif

    assign reload = BURST_W'(max_one(32'(burst_len)));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pending_d   = pending_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        frame_d     = frame_q;
        err_d       = err_q & ~err_clr;

        if (press_any && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (press_any && !txif.tx_busy) begin
                    remaining_d = reload;
                    state_d     = ST_ARM;
                end
            end
            ST_ARM: begin
                // tmo counts cycles elapsed since tx_start, the ARM cycle being cycle 0
                tmo_d   = TMO_W'(1);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (txif.tx_busy) begin
                    state_d = ST_SENDING;
                end else if (tmo_q >= TMO_W'(START_TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    remaining_d = '0;
                    pending_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_SENDING: begin
                if (!txif.tx_busy) begin
                    frame_d     = frame_q + 8'd1;
                    remaining_d = remaining_q - BURST_W'(1);
                    gap_d       = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES)) begin
                    if (remaining_q != '0) begin
                        state_d = ST_ARM;
                    end else if (pending_q || press_any) begin
                        // a press landing on the final gap cycle is served, not stranded
                        pending_d   = 1'b0;
                        remaining_d = reload;
                        state_d     = ST_ARM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_start_d = (state_d == ST_ARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            pending_q   <= 1'b0;
            tmo_q       <= '0;
            gap_q       <= '0;
            frame_q     <= 8'd0;
            err_q       <= 1'b0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign txif.tx_start = tx_start_q;
    assign sched_busy    = (state_q != ST_IDLE);
    assign frame_cnt     = frame_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_tx_send_scheduler.sv
// Testbench for tx_send_scheduler: bouncy key stimulus, randomized bursts and a
// transmitter model, checked against frame-level timing rules of the scheduler.
module tb_tx_send_scheduler;

    localparam int DEB = 8;
    localparam int GAP = 5;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic [3:0] burst_len = 4'd1;
    logic       err_clr = 1'b0;
    logic       sched_busy;
    logic [7:0] frame_cnt;
    logic       err_timeout;

    tx_send_scheduler_if txif();

    tx_send_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .GAP_CYCLES     (GAP),
        .START_TIMEOUT  (TMO),
        .BURST_W        (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .burst_len  (burst_len),
        .err_clr    (err_clr),
`ifdef TX_SCHED_AUTO_EN
        .auto_en    (1'b0),
`endif
        .txif       (txif),
        .sched_busy (sched_busy),
        .frame_cnt  (frame_cnt),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Transmitter model: goes busy tx_dly cycles after tx_start, for tx_len cycles.
    int tx_dly = 2, tx_len = 20, tx_s = 0;
    bit tx_act = 0, tx_dead = 0, tx_force = 0;
    initial txif.tx_busy = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_act = 0;
            txif.tx_busy = 1'b0;
        end else begin
            if (txif.tx_start) begin
                tx_act = 1;
                tx_s = 0;
            end else if (tx_act) begin
                tx_s++;
            end
            if (tx_act && tx_s >= tx_dly + tx_len) tx_act = 0;
            txif.tx_busy = tx_force || (tx_act && !tx_dead && tx_s >= tx_dly);
        end
    end

    // Output monitor: start times, pulse widths, press events, edges of err/busy.
    int starts[$];
    int n_press = 0, press_cyc = -1, n_wide = 0, err_rise = -1, idle_fall = -1;
    bit prev_start = 0, prev_err = 0, prev_busy = 0;
    always @(negedge clk) begin
        if (txif.tx_start) begin
            if (prev_start) n_wide++;
            else starts.push_back(cyc);
        end
        if (dut.press_evt) begin
            n_press++;
            press_cyc = cyc;
        end
        if (err_timeout && !prev_err) err_rise = cyc;
        if (!sched_busy && prev_busy) idle_fall = cyc;
        prev_start = txif.tx_start;
        prev_err   = err_timeout;
        prev_busy  = sched_busy;
    end

    function automatic int ref_frames(input int b);
        return (b == 0) ? 1 : b;
    endfunction

    function automatic int ref_spacing();
        return tx_dly + tx_len + GAP + 2;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int key_fall = 0;
    task automatic press_key(input int nb, input int low_c, input int high_c);
        for (int i = 0; i < nb; i++) begin
            key_n = 1'b0; wait_cyc(2);
            key_n = 1'b1; wait_cyc(2);
        end
        key_n = 1'b0;
        key_fall = cyc;
        wait_cyc(low_c);
        key_n = 1'b1;
        wait_cyc(high_c);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int i;
        for (i = 0; i < limit && sched_busy; i++) wait_cyc(1);
        if (sched_busy) check_eq(tag, 1, 0);
        wait_cyc(4);
    endtask

    int ref_fc = 0;
    int t0, n0, need, b, b1, b2, q2, exp_n, fall1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        wait_cyc(3);
        check_eq("rst_tx_start", int'(txif.tx_start), 0);
        check_eq("rst_sched_busy", int'(sched_busy), 0);
        check_eq("rst_frame_cnt", int'(frame_cnt), 0);
        check_eq("rst_err", int'(err_timeout), 0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Bouncy press, single frame
        tx_dly = 2; tx_len = 20; burst_len = 4'd1;
        starts.delete(); n0 = n_press;
        press_key(3, 20, 14);
        wait_idle("bnc_idle", 300);
        check_eq("bnc_press_evts", n_press - n0, 1);
        check_eq("bnc_starts", starts.size(), 1);
        if (starts.size() > 0) begin
            check_eq("bnc_evt_to_start", starts[0] - press_cyc, 1);
            check_eq("bnc_key_to_start", starts[0] - key_fall, DEB + 3);
        end
        ref_fc = (ref_fc + 1) % 256;
        check_eq("bnc_frame_cnt", int'(frame_cnt), ref_fc);

        // Burst of 3
        burst_len = 4'd3; starts.delete();
        press_key(0, 14, 14);
        wait_idle("burst_idle", 500);
        check_eq("burst_starts", starts.size(), 3);
        for (int k = 1; k < starts.size(); k++)
            check_eq("burst_spacing", starts[k] - starts[k-1], 29);
        if (starts.size() > 0)
            check_eq("burst_busy_fall", idle_fall - starts[starts.size()-1], ref_spacing());
        ref_fc = (ref_fc + 3) % 256;
        check_eq("burst_frame_cnt", int'(frame_cnt), ref_fc);

        // Press while transmitter already busy in IDLE is dropped
        tx_force = 1; burst_len = 4'd1; starts.delete();
        press_key(0, 14, 14);
        wait_cyc(10);
        check_eq("busy_drop_starts", starts.size(), 0);
        check_eq("busy_drop_idle", int'(sched_busy), 0);
        tx_force = 0;
        wait_cyc(4);

        // Start timeout
        tx_dead = 1; starts.delete();
        press_key(0, 14, 14);
        check_eq("tmo_start", starts.size(), 1);
        if (starts.size() > 0) begin
            check_eq("tmo_err_delay", err_rise - starts[0], TMO);
            check_eq("tmo_idle_delay", idle_fall - starts[0], TMO);
        end
        check_eq("tmo_err_set", int'(err_timeout), 1);
        err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0;
        check_eq("tmo_err_cleared", int'(err_timeout), 0);
        starts.delete();
        press_key(0, 14, 0);
        check_eq("tmo2_start", starts.size(), 1);
        if (starts.size() > 0) begin
            t0 = starts[0];
            for (int g = 0; g < 100 && cyc < t0 + TMO - 1; g++) wait_cyc(1);
            err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0;
            check_eq("tmo_set_wins", int'(err_timeout), 1);
            check_eq("tmo2_err_delay", err_rise - t0, TMO);
        end
        wait_cyc(14);
        tx_dead = 0;

        // One-deep queue: two extra presses during SENDING -> two frames
        tx_dly = 2; tx_len = 60; burst_len = 4'd1; starts.delete();
        press_key(0, 14, 14);
        press_key(0, 14, 14);
        press_key(0, 14, 14);
        wait_idle("queue_idle", 600);
        check_eq("queue_starts", starts.size(), 2);
        if (starts.size() == 2)
            check_eq("queue_spacing", starts[1] - starts[0], ref_spacing());
        ref_fc = (ref_fc + 2) % 256;
        check_eq("queue_frame_cnt", int'(frame_cnt), ref_fc);

        // Burst length zero sends one frame
        tx_len = 20; burst_len = 4'd0; starts.delete();
        press_key(0, 14, 14);
        wait_idle("zero_idle", 300);
        check_eq("zero_starts", starts.size(), ref_frames(0));
        ref_fc = (ref_fc + 1) % 256;

        // Reset during SENDING with a queued press
        tx_len = 60; burst_len = 4'd1; starts.delete();
        press_key(0, 14, 14);
        press_key(0, 14, 14);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx_start", int'(txif.tx_start), 0);
        check_eq("mid_rst_sched_busy", int'(sched_busy), 0);
        check_eq("mid_rst_frame_cnt", int'(frame_cnt), 0);
        check_eq("mid_rst_err", int'(err_timeout), 0);
        wait_cyc(3);
        rst_n = 1'b1;
        ref_fc = 0;
        starts.delete();
        wait_cyc(100);
        check_eq("post_rst_no_queue", starts.size(), 0);
        check_eq("post_rst_frame_cnt", int'(frame_cnt), 0);
        tx_len = 20;
        press_key(0, 14, 14);
        wait_idle("post_rst_idle", 300);
        check_eq("post_rst_starts", starts.size(), 1);
        ref_fc = (ref_fc + 1) % 256;
        check_eq("post_rst_fcnt", int'(frame_cnt), ref_fc);

        // Drive frame_cnt to 255 with short frames, then wrap
        tx_dly = 1; tx_len = 1;
        need = 255 - ref_fc;
        while (need > 0) begin
            b = (need > 15) ? 15 : need;
            burst_len = 4'(b);
            press_key(0, 14, 14);
            wait_idle("wrap_fill_idle", 400);
            need -= b;
            ref_fc = (ref_fc + b) % 256;
        end
        check_eq("wrap_at_255", int'(frame_cnt), ref_fc);
        burst_len = 4'd1;
        press_key(0, 14, 14);
        wait_idle("wrap_idle", 200);
        ref_fc = (ref_fc + 1) % 256;
        check_eq("wrap_to_0", int'(frame_cnt), ref_fc);

        // Randomized bursts with optional queued press
        for (int it = 0; it < 10; it++) begin
            b1 = $urandom_range(0, 4);
            b2 = $urandom_range(0, 3);
            q2 = $urandom_range(0, 1);
            tx_dly = $urandom_range(1, 4);
            tx_len = $urandom_range(35, 45);
            burst_len = 4'(b1);
            starts.delete();
            press_key($urandom_range(0, 2), 14, 14);
            fall1 = key_fall;
            burst_len = 4'(b2);
            if (q2 != 0) press_key($urandom_range(0, 2), 14, 14);
            wait_idle("rnd_idle", 2000);
            exp_n = ref_frames(b1) + ((q2 != 0) ? ref_frames(b2) : 0);
            check_eq("rnd_starts", starts.size(), exp_n);
            if (starts.size() > 0)
                check_eq("rnd_latency", starts[0] - fall1, DEB + 3);
            for (int k = 1; k < starts.size(); k++)
                check_eq("rnd_spacing", starts[k] - starts[k-1], ref_spacing());
            ref_fc = (ref_fc + exp_n) % 256;
            check_eq("rnd_frame_cnt", int'(frame_cnt), ref_fc);
        end

        check_eq("start_pulse_width", n_wide, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_send_scheduler.md
Name: tx_send_scheduler

Overview:
Sequences frame transmission for the Tx node: debounces the raw Send key, turns each press into one or more tx_start pulses for tx_transmitter, waits out each frame via tx_busy, and enforces an inter-frame gap. It replaces the direct inverted-key connection to tx_start. It also adds burst repeat, a one-deep press queue, start-timeout detection and a sent-frame counter for status LEDs and HEX.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive identical synchronized samples needed to accept a key level (20 ms at 50 MHz)
GAP_CYCLES, 50000, idle cycles enforced after tx_busy falls and before the next tx_start
START_TIMEOUT, 1024, cycles allowed from tx_start until tx_busy rises
BURST_W, 4, width of burst_len

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous, active-low reset
key_n  in  1  raw Send key, active-low, asynchronous, bouncy
burst_len  in  BURST_W  frames per accepted press; sampled at press acceptance; 0 treated as 1
tx_busy  in  1  busy flag from tx_transmitter
err_clr  in  1  clears err_timeout
tx_start  out  1  one-cycle start pulse to tx_transmitter
sched_busy  out  1  high in every state except IDLE
frame_cnt  out  8  count of completed frames, wraps 255 to 0
err_timeout  out  1  sticky; transmitter failed to go busy

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Debounced level = 1 (released). All counters cleared. Pending flag cleared. Asserting rst_n mid-frame aborts immediately, with no tx_start glitch.
- Key path: 2-flop synchronizer, then a counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it. press_evt is a one-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- FSM states: IDLE, ARM, WAIT_BUSY, SENDING, GAP.
- IDLE: on press_evt with tx_busy low, load remaining = max(burst_len,1) and go to ARM. A press_evt while tx_busy is high in IDLE is dropped.
- ARM: tx_start = 1 for exactly this cycle (registered). Next state WAIT_BUSY; clear the timeout counter. Latency: press_evt in cycle N gives tx_start high in cycle N+1.
- WAIT_BUSY: tx_busy high goes to SENDING. If the timeout counter reaches START_TIMEOUT: set err_timeout, clear remaining and pending, go to IDLE.
- SENDING: on tx_busy low, frame_cnt+1 (mod 256), remaining-1, go to GAP with the gap counter cleared.
- GAP: count GAP_CYCLES cycles, then:
  - remaining != 0: go to ARM.
  - else pending set: clear pending, reload remaining from current burst_len (0 treated as 1), go to ARM.
  - else go to IDLE.
- A press_evt in any non-IDLE state sets pending. Queue depth is one; further presses are lost.
- err_timeout: when set and err_clr occur in the same cycle, set wins. err_timeout does not block new presses.
- Width rules: remaining is BURST_W bits. The timeout and gap counters are sized with clog2 of (parameter+1).

Optional Feature:
TX_SCHED_AUTO_EN. When defined:
- Adds input auto_en (1 bit) and parameter AUTO_PERIOD (default 50000000).
- While auto_en is high and the FSM is in IDLE, a free-running period counter injects a press_evt every AUTO_PERIOD cycles.
- The counter resets whenever the FSM leaves IDLE or auto_en is low.
When undefined: no auto_en port and no period counter; behaviour is exactly as above.

Decomposition:
- Package tx_sched_pkg: FSM state enum, default constants for DEBOUNCE_CYCLES, GAP_CYCLES, START_TIMEOUT and AUTO_PERIOD, and a max_one(burst) function mapping 0 to 1.
- One sub-module, tx_key_debouncer: synchronizer, debounce counter and press_evt output. It is reusable for the Load key.

Test Plan:
- DEBOUNCE_CYCLES=8: key_n bounces low/high 3 times at 2-cycle spacing, then stays low 20 cycles -> exactly one press_evt; tx_start high 1 cycle, 1 cycle after press_evt.
- burst_len=3, GAP_CYCLES=5, transmitter model busy for 20 cycles starting 2 cycles after tx_start -> 3 tx_start pulses; consecutive pulses are 29 cycles apart, i.e. 2 (start to busy rise) + 20 (busy) + 5 (gap) + 2 (FSM transitions: SENDING->GAP, GAP->ARM). frame_cnt 0->3; sched_busy falls after the final gap.
- tx_busy held 0, START_TIMEOUT=16 -> err_timeout rises 16 cycles after tx_start; FSM in IDLE; err_clr pulse clears it; err_clr coincident with a new timeout leaves it set.
- burst_len=1, two presses during SENDING -> exactly 2 frames total (one queued, second press lost). burst_len=0 -> exactly 1 frame.
- rst_n low during SENDING -> all outputs 0 immediately. After release: frame_cnt=0, no queued frame; a new press sends normally.
- Preload frame_cnt=255 via 255 frames (short timings) -> next frame wraps frame_cnt to 0.
